// File: rtl/mc_controller_hs.sv
// Multicycle MIPS control FSM with a memory ready/wait handshake, an illegal-instruction
// trap, ANDI/ORI zero-extend select, and free-running cycle / retired-instruction counters.
module mc_controller_hs #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             immext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucont,
  output logic [4:0]       state_o,
  output logic             illegal,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,  DECODE  = 5'd1,  MEMADR  = 5'd2,  MEMRD  = 5'd3,
    MEMWB   = 5'd4,  MEMWR   = 5'd5,  RTYPEEX = 5'd6,  RTYPEWB = 5'd7,
    BEQEX   = 5'd8,  BNEEX   = 5'd9,  IMMEX   = 5'd10, IMMWB  = 5'd11,
    JEX     = 5'd12, ILLEGAL = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t state, nextstate;
  logic   ready;

  assign ready   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_o = state;

  function automatic logic legal_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextstate = state;
    case (state)
      FETCH:  if (ready) nextstate = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                       nextstate = MEMADR;
          OP_BEQ:                             nextstate = BEQEX;
          OP_BNE:                             nextstate = BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  nextstate = IMMEX;
          OP_J:                               nextstate = JEX;
          OP_RTYPE: begin
            if (funct == 6'h00)          nextstate = FETCH;
            else if (legal_funct(funct)) nextstate = RTYPEEX;
            else                         nextstate = ILLEGAL;
          end
          default:                            nextstate = ILLEGAL;
        endcase
      end
      MEMADR:  nextstate = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (ready) nextstate = MEMWB;
      MEMWR:   if (ready) nextstate = FETCH;
      RTYPEEX: nextstate = RTYPEWB;
      IMMEX:   nextstate = IMMWB;
      MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX: nextstate = FETCH;
      ILLEGAL: nextstate = ILLEGAL;
      default: nextstate = FETCH;
    endcase
  end

  // Outputs decode straight from the state register, so an async reset into FETCH
  // withdraws a pending write the instant reset_n falls.
  always_comb begin
    pcen     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    immext   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alucont  = ALU_ADD;
    case (state)
      FETCH: begin
        memread = reset_n;
        alusrcb = 2'b01;
        irwrite = reset_n & ready;
        pcen    = reset_n & ready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucont = funct_alu(funct);
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        alucont = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = (state == BEQEX) ? zero : ~zero;
      end
      IMMEX, IMMWB: begin
        alusrca  = (state == IMMEX);
        alusrcb  = (state == IMMEX) ? 2'b10 : 2'b00;
        regwrite = (state == IMMWB);
        alucont  = imm_alu(op);
        immext   = (op == OP_ANDI) || (op == OP_ORI);
      end
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      cycles  <= '0;
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nextstate;
      if (state != ILLEGAL)
        cycles <= cycles + CNT_W'(1);
      if (nextstate == FETCH && state != FETCH)
        instret <= instret + CNT_W'(1);
      if (nextstate == ILLEGAL)
        illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: handshake stalls, branches, immediates, trap and
// mid-access reset, checked with immediate assertions against hand-computed values.
module tb_mc_controller_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg;
  logic        regdst, immext, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucont;
  logic [4:0]  state_o;
  logic [31:0] cycles, instret;
  logic [16:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;
  int ir_cnt, pc_cnt;

  localparam logic [4:0] S_FETCH = 5'd0, S_DECODE = 5'd1, S_MEMADR = 5'd2, S_MEMRD = 5'd3,
                         S_MEMWB = 5'd4, S_MEMWR = 5'd5, S_RTYPEEX = 5'd6, S_RTYPEWB = 5'd7,
                         S_BEQEX = 5'd8, S_BNEEX = 5'd9, S_IMMEX = 5'd10, S_IMMWB = 5'd11,
                         S_JEX = 5'd12, S_ILLEGAL = 5'd13;

  // ctrl field order: {pcen,memread,memwrite,irwrite,regwrite}_{alusrca,iord,memtoreg,regdst,immext}_alusrcb_pcsrc_alucont
  localparam logic [16:0] C_RST      = 17'b00000_00000_01_00_010;
  localparam logic [16:0] C_FETCHW   = 17'b01000_00000_01_00_010;
  localparam logic [16:0] C_FETCHR   = 17'b11010_00000_01_00_010;
  localparam logic [16:0] C_DECODE   = 17'b00000_00000_11_00_010;
  localparam logic [16:0] C_MEMADR   = 17'b00000_10000_10_00_010;
  localparam logic [16:0] C_MEMRD    = 17'b01000_01000_00_00_010;
  localparam logic [16:0] C_MEMWB    = 17'b00001_00100_00_00_010;
  localparam logic [16:0] C_MEMWR    = 17'b00100_01000_00_00_010;
  localparam logic [16:0] C_BEQ_Z1   = 17'b10000_10000_00_01_110;
  localparam logic [16:0] C_BNE_Z1   = 17'b00000_10000_00_01_110;
  localparam logic [16:0] C_ORI_EX   = 17'b00000_10001_10_00_001;
  localparam logic [16:0] C_ORI_WB   = 17'b00001_00001_00_00_001;
  localparam logic [16:0] C_SLTI_EX  = 17'b00000_10000_10_00_111;
  localparam logic [16:0] C_SLTI_WB  = 17'b00001_00000_00_00_111;
  localparam logic [16:0] C_SUB_EX   = 17'b00000_10000_00_00_110;
  localparam logic [16:0] C_RTYPE_WB = 17'b00001_00010_00_00_010;
  localparam logic [16:0] C_JEX      = 17'b10000_00000_00_10_010;
  localparam logic [16:0] C_ILLEGAL  = 17'b00000_00000_00_00_010;

  localparam logic [4:0] LW_SEQ [10] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE,
                                         S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};

  assign ctrl = {pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
                 regdst, immext, alusrcb, pcsrc, alucont};

  mc_controller_hs #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .immext(immext),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucont(alucont), .state_o(state_o), .illegal(illegal),
    .cycles(cycles), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step just past it so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("rst_ctrl", ctrl, C_RST);
    check("rst_state", state_o, S_FETCH);
    check("rst_cycles", cycles, 0);
    check("rst_instret", instret, 0);
    check("rst_illegal", illegal, 0);
    tick();
    check("rst_hold_cycles", cycles, 0);

    // LW: three FETCH stalls, two MEMRD stalls
    op = 6'h23; mem_ready = 1'b0; reset_n = 1'b1;
    #2;
    check("lw_fetch_wait", ctrl, C_FETCHW);
    ir_cnt = 0; pc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = (i == 3) || (i == 8);
      #2;
      check($sformatf("lw_state%0d", i), state_o, LW_SEQ[i]);
      ir_cnt += int'(irwrite);
      pc_cnt += int'(pcen);
      if (i == 6) check("lw_memrd_ctrl", ctrl, C_MEMRD);
      if (i == 9) begin
        check("lw_memwb_ctrl", ctrl, C_MEMWB);
        check("lw_memwb_cycles", cycles, 9);
      end
      if (i < 9) tick();
    end
    check("lw_irwrite_pulses", ir_cnt, 1);
    check("lw_pcen_pulses", pc_cnt, 1);
    tick();
    check("lw_done_state", state_o, S_FETCH);
    check("lw_instret", instret, 1);
    check("lw_cycles", cycles, 10);

    // SW: MEMWR stalls four cycles with outputs steady
    op = 6'h2B; mem_ready = 1'b1;
    #2;
    check("sw_fetch_ready", ctrl, C_FETCHR);
    tick(); #2;
    check("sw_decode", ctrl, C_DECODE);
    tick(); #2;
    check("sw_memadr", ctrl, C_MEMADR);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #2;
      check($sformatf("sw_memwr%0d", i), ctrl, C_MEMWR);
      if (i < 4) tick();
    end
    tick(); #2;
    check("sw_done_state", state_o, S_FETCH);
    check("sw_instret", instret, 2);

    // BEQ and BNE with zero=1
    op = 6'h04; tick(); tick();
    zero = 1'b1; #2;
    check("beq_ctrl", ctrl, C_BEQ_Z1);
    tick(); #2;
    check("beq_done", state_o, S_FETCH);
    op = 6'h05; tick(); tick(); #2;
    check("bne_ctrl", ctrl, C_BNE_Z1);
    tick(); #2;
    check("bne_done", state_o, S_FETCH);
    zero = 1'b0;

    // ORI then SLTI
    op = 6'h0D; tick(); tick(); #2;
    check("ori_ex", ctrl, C_ORI_EX);
    tick(); #2;
    check("ori_wb", ctrl, C_ORI_WB);
    tick();
    op = 6'h0A; tick(); tick(); #2;
    check("slti_ex", ctrl, C_SLTI_EX);
    tick(); #2;
    check("slti_wb", ctrl, C_SLTI_WB);
    tick();

    // R-type SUB, J, then a funct-00 bubble
    op = 6'h00; funct = 6'h22; tick(); tick(); #2;
    check("sub_ex", ctrl, C_SUB_EX);
    tick(); #2;
    check("rtype_wb", ctrl, C_RTYPE_WB);
    tick();
    op = 6'h02; tick(); tick(); #2;
    check("jex", ctrl, C_JEX);
    tick();
    op = 6'h00; funct = 6'h00; tick(); tick(); #2;
    check("bubble_state", state_o, S_FETCH);
    check("bubble_instret", instret, 9);
    check("bubble_cycles", cycles, 41);

    // Illegal opcode traps and freezes the cycle counter
    op = 6'h3F; zero = 1'b1; tick(); tick(); #2;
    check("ill_state", state_o, S_ILLEGAL);
    check("ill_flag", illegal, 1);
    check("ill_ctrl", ctrl, C_ILLEGAL);
    repeat (20) tick();
    check("ill_cycles_frozen", cycles, 43);
    check("ill_state_held", state_o, S_ILLEGAL);
    check("ill_instret", instret, 9);
    reset_n = 1'b0; #1;
    check("ill_rst_state", state_o, S_FETCH);
    check("ill_rst_flag", illegal, 0);
    check("ill_rst_cycles", cycles, 0);

    // Reset pulsed in the middle of a store
    tick();
    op = 6'h2B; zero = 1'b0; mem_ready = 1'b1; reset_n = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); #2;
    check("mw_rst_before", memwrite, 1);
    reset_n = 1'b0; #1;
    check("mw_rst_memwrite", memwrite, 0);
    check("mw_rst_memread", memread, 0);
    check("mw_rst_state", state_o, S_FETCH);
    tick();
    reset_n = 1'b1; #1;
    check("mw_rel_state", state_o, S_FETCH);
    check("mw_rel_cycles", cycles, 0);
    check("mw_rel_instret", instret, 0);
    tick();
    check("mw_rel_cycles1", cycles, 1);
    check("mw_rel_instret1", instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
